gb_irq_ctrl: RTL and testbench
==============================

# gb_irq_ctrl

Parametrised interrupt controller for the Game Boy core that replaces the fixed 5-source IF/IE logic in the top level. It provides:
- Up to 8 sources with per-source edge/level and polarity selection.
- CPU-visible IF/IE registers.
- A priority-encoded, parametrised vector.
- An acknowledge FSM that freezes the vector for the whole ack cycle and clears exactly the acknowledged flag.

It sits between the peripherals (video, timer, serial, joypad) and the GBse CPU's INT_n/DI path.

## Interface
Parameters:
- NUM_IRQ, 5, number of sources (1..8).
- EDGE_MASK, 8'h1D, per bit: 1 = edge-triggered, 0 = level-triggered.
- POL_MASK, 8'h10, per bit: 1 = source active-low (inverted before detection).
- VEC_BASE, 8'h40, vector of source 0.
- VEC_STRIDE, 8'h08, vector spacing.
- DEFAULT_VEC, 8'h55, vector driven when nothing is pending+enabled.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- irq_src  in  NUM_IRQ  raw source lines, synchronous to clk.
- sel_ie  in  1  CPU addresses IE ($FFFF).
- sel_if  in  1  CPU addresses IF ($FF0F).
- cpu_wr  in  1  CPU write strobe (level).
- cpu_di  in  8  CPU write data.
- ie_do  out  8  IE readback; bits ≥ NUM_IRQ read 0.
- if_do  out  8  IF readback; bits ≥ NUM_IRQ read 1.
- cpu_ack  in  1  interrupt-acknowledge level (IORQ & M1 active).
- irq_n  out  1  low while (IF & IE) ≠ 0.
- irq_vec  out  8  vector for CPU DI during ack.
- wake  out  1  high while (IF & IE) ≠ 0; for HALT exit.

## Operation
- **Normalisation:** s = irq_src ^ POL_MASK[NUM_IRQ-1:0].
- **Edge detection:** s_d registers s every cycle; s_d reset value is all ones, so no spurious edge after reset.
- **Set vector:** set[i] = EDGE_MASK[i] ? (s[i] & ~s_d[i]) : s[i].
- **Flag update:** ack_d registers cpu_ack.
  - base = (sel_if & cpu_wr) ? cpu_di : (if_r & ~clr).
  - if_r ← base | set.
  - Priority: event set beats CPU write, CPU write beats ack clear.
  - A write held several cycles rewrites every cycle.
- **IE:** ie_r ← cpu_di[NUM_IRQ-1:0] when sel_ie & cpu_wr.
- **Winner:** lowest index i with if_r[i] & ie_r[i].
- **Vector arithmetic:** VEC_BASE + i*VEC_STRIDE, 8-bit, wraps modulo 256.
- **Ack FSM**, states IDLE and ACK:
  - IDLE → ACK on ack rise (cpu_ack & ~ack_d). Latch ack_idx = winner and ack_hit = winner exists.
  - In ACK, irq_vec = latched vector (DEFAULT_VEC if !ack_hit), frozen even if flags change.
  - ACK → IDLE on ack fall (~cpu_ack & ack_d). clr = one-hot(ack_idx) if ack_hit for that single cycle; otherwise clr = 0.
  - In IDLE, irq_vec = combinational vector of the current winner, or DEFAULT_VEC.
- **Level sources:** a flag cleared by ack or write is re-set next cycle while the source is still active.
- **Outputs:** irq_n and wake decode the registered if_r/ie_r combinationally.

## Timing
- **Reset values:** if_r = 0, ie_r = 0, s_d = all ones, ack_d = 0, state = IDLE.
  - Outputs: irq_n = 1, wake = 0, irq_vec = DEFAULT_VEC, ie_do = 8'h00, if_do = {(8-NUM_IRQ){1}, 0...}.
- **Latency:** active source edge sampled at edge n → if_r set at edge n → irq_n low after edge n (1 cycle from source assertion). IE/IF writes are visible on readback and irq_n the next cycle.
- **Clear timing:** the clear lands on the edge that samples cpu_ack low (ack_d still 1). if_r bit is 0 one cycle after ack falls, unless re-set by the same source.
- **Simultaneous events:**
  - Two sources same cycle: both flags set; winner is the lower index.
  - Source event on the clear cycle of the same bit: flag stays 1.
  - IF write on the clear cycle: written value wins over the clear.
- **Reset mid-ACK:** FSM returns to IDLE immediately (async); no clear issued after release.
- **Ack without pending:** vector DEFAULT_VEC; no flag touched.

## Test plan
- **Reset, defaults:** with default parameters, assert reset mid-run → if_do = 8'hE0, ie_do = 8'h00, irq_n = 1, irq_vec = 8'h55, immediately (async).
- **Single edge source:** ie = 8'h04, pulse irq_src[2] one cycle → if_do = 8'hE4 next cycle, irq_n = 0. Ack high 2 cycles → irq_vec = 8'h50. After ack falls → if_do = 8'hE0, irq_n = 1.
- **Priority and freeze:** ie = 8'h1F, raise src1 and src3. Ack rise → vec 8'h48. Raise src0 during ACK → vec stays 8'h48. After fall → only bit 1 cleared, if_do = 8'hE9, idle vec = 8'h40.
- **Active-low joypad edge:** src4 held high after reset → no flag. Drive 1→0 → if_r[4] = 1. Hold 0 → no further set after CPU writes IF = 0.
- **Collisions:** src2 rising edge on the clear cycle of bit 2 → bit 2 remains 1. Write IF = 8'h00 on the clear cycle with no event → if_do = 8'hE0.
- **Parametrised config:** NUM_IRQ = 8, EDGE_MASK = 0, VEC_BASE = 8'hF0, VEC_STRIDE = 8'h08. Level src7 with ie = 8'h80 → vec = 8'h28 (wraps). Flag re-sets each cycle after ack while src7 is high. if_do = 8'h80.

Source files
------------

// File: rtl/gb_irq_ctrl.sv
// Parametrised interrupt controller: per-source edge/level and polarity detection,
// CPU-visible IF/IE registers, priority-encoded vector and an acknowledge FSM.
module gb_irq_ctrl #(
    parameter int          NUM_IRQ     = 5,
    parameter logic [7:0]  EDGE_MASK   = 8'h1D,
    parameter logic [7:0]  POL_MASK    = 8'h10,
    parameter logic [7:0]  VEC_BASE    = 8'h40,
    parameter logic [7:0]  VEC_STRIDE  = 8'h08,
    parameter logic [7:0]  DEFAULT_VEC = 8'h55
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               sel_ie,
    input  logic               sel_if,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_di,
    output logic [7:0]         ie_do,
    output logic [7:0]         if_do,
    input  logic               cpu_ack,
    output logic               irq_n,
    output logic [7:0]         irq_vec,
    output logic               wake
);

    localparam logic [NUM_IRQ-1:0] EDGE_SEL = EDGE_MASK[NUM_IRQ-1:0];
    localparam logic [NUM_IRQ-1:0] POL_SEL  = POL_MASK[NUM_IRQ-1:0];

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_if;
    logic [NUM_IRQ-1:0] r_ie;
    logic [NUM_IRQ-1:0] r_s_d;
    logic               r_ack_d;
    logic               r_ack_hit;
    logic [2:0]         r_ack_idx;
    logic [7:0]         r_ack_vec;

    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_base;
    logic               w_hit;
    logic [2:0]         w_idx;
    logic [7:0]         w_idx8;
    logic [7:0]         w_win_vec;
    logic               w_ack_rise;
    logic               w_ack_fall;
    logic               w_if_wr;
    logic               w_ie_wr;

    assign w_s        = irq_src ^ POL_SEL;
    assign w_set      = (EDGE_SEL & w_s & ~r_s_d) | (~EDGE_SEL & w_s);
    assign w_pend     = r_if & r_ie;
    assign w_ack_rise = cpu_ack & ~r_ack_d;
    assign w_ack_fall = ~cpu_ack & r_ack_d;
    assign w_if_wr    = sel_if & cpu_wr;
    assign w_ie_wr    = sel_ie & cpu_wr;

    // Descending scan so the lowest pending+enabled index is the one that sticks.
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_hit = 1'b1;
                w_idx = 3'(i);
            end
        end
    end

    assign w_idx8    = {5'b00000, w_idx};
    assign w_win_vec = w_hit ? (VEC_BASE + w_idx8 * VEC_STRIDE) : DEFAULT_VEC;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = (r_state == ACK) && w_ack_fall && r_ack_hit && (r_ack_idx == 3'(i));
        end
    end

    // Source events override a CPU write, which overrides the ack clear.
    assign w_base = w_if_wr ? cpu_di[NUM_IRQ-1:0] : (r_if & ~w_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if    <= '0;
            r_ie    <= '0;
            r_s_d   <= '1;
            r_ack_d <= 1'b0;
        end else begin
            r_if    <= w_base | w_set;
            r_s_d   <= w_s;
            r_ack_d <= cpu_ack;
            if (w_ie_wr) begin
                r_ie <= cpu_di[NUM_IRQ-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ack_hit <= 1'b0;
            r_ack_idx <= 3'd0;
            r_ack_vec <= DEFAULT_VEC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ack_rise) begin
                        r_state   <= ACK;
                        r_ack_hit <= w_hit;
                        r_ack_idx <= w_idx;
                        r_ack_vec <= w_win_vec;
                    end
                end
                ACK: begin
                    if (w_ack_fall) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The vector is frozen for the whole ack so the CPU reads a stable value.
    assign irq_vec = (r_state == ACK) ? r_ack_vec : w_win_vec;
    assign irq_n   = ~(|w_pend);
    assign wake    = |w_pend;

    always_comb begin
        if_do                = 8'hFF;
        if_do[NUM_IRQ-1:0]   = r_if;
        ie_do                = 8'h00;
        ie_do[NUM_IRQ-1:0]   = r_ie;
    end

    generate
        if (NUM_IRQ < 8) begin : g_pad
            logic w_unused_di;
            assign w_unused_di = ^cpu_di[7:NUM_IRQ];
        end
    endgenerate

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Directed bench for gb_irq_ctrl: a vector table on the default configuration
// plus hand sequences for reset-mid-ack and an 8-source level configuration.
module tb_gb_irq_ctrl;

    typedef struct {
        logic [4:0] src;
        logic       selIe;
        logic       selIf;
        logic       wr;
        logic [7:0] di;
        logic       ack;
        logic [7:0] expIf;
        logic [7:0] expIe;
        logic       expIrqN;
        logic [7:0] expVec;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic [4:0] src1 = 5'b10000;
    logic       selIe1 = 1'b0, selIf1 = 1'b0, wr1 = 1'b0, ack1 = 1'b0;
    logic [7:0] di1 = 8'h00;
    logic [7:0] ieDo1, ifDo1, vec1;
    logic       irqN1, wake1;

    logic [7:0] src2 = 8'h00;
    logic       selIe2 = 1'b0, selIf2 = 1'b0, wr2 = 1'b0, ack2 = 1'b0;
    logic [7:0] di2 = 8'h00;
    logic [7:0] ieDo2, ifDo2, vec2;
    logic       irqN2, wake2;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    gb_irq_ctrl dut (
        .clk(clk), .reset(reset), .irq_src(src1),
        .sel_ie(selIe1), .sel_if(selIf1), .cpu_wr(wr1), .cpu_di(di1),
        .ie_do(ieDo1), .if_do(ifDo1), .cpu_ack(ack1),
        .irq_n(irqN1), .irq_vec(vec1), .wake(wake1)
    );

    gb_irq_ctrl #(
        .NUM_IRQ(8), .EDGE_MASK(8'h00), .POL_MASK(8'h00),
        .VEC_BASE(8'hF0), .VEC_STRIDE(8'h08), .DEFAULT_VEC(8'h55)
    ) dut8 (
        .clk(clk), .reset(reset), .irq_src(src2),
        .sel_ie(selIe2), .sel_if(selIf2), .cpu_wr(wr2), .cpu_di(di2),
        .ie_do(ieDo2), .if_do(ifDo2), .cpu_ack(ack2),
        .irq_n(irqN2), .irq_vec(vec2), .wake(wake2)
    );

    function automatic vec_t mkVec(input logic [4:0] src, input logic selIe, input logic selIf,
                                   input logic wr, input logic [7:0] di, input logic ack,
                                   input logic [7:0] expIf, input logic [7:0] expIe,
                                   input logic expIrqN, input logic [7:0] expVec);
        vec_t v;
        v.src = src; v.selIe = selIe; v.selIf = selIf; v.wr = wr; v.di = di; v.ack = ack;
        v.expIf = expIf; v.expIe = expIe; v.expIrqN = expIrqN; v.expVec = expVec;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    // Drive one record's inputs and let one rising edge sample them.
    task automatic applyStimulus(input vec_t v);
        src1 = v.src; selIe1 = v.selIe; selIf1 = v.selIf; wr1 = v.wr; di1 = v.di; ack1 = v.ack;
        @(posedge clk);
        #1;
    endtask

    task automatic checkRow(input vec_t v, input string tag);
        checkOutput({tag, "_if"},   ifDo1, v.expIf);
        checkOutput({tag, "_ie"},   ieDo1, v.expIe);
        checkOutput({tag, "_irqn"}, {7'b0, irqN1}, {7'b0, v.expIrqN});
        checkOutput({tag, "_wake"}, {7'b0, wake1}, {7'b0, ~v.expIrqN});
        checkOutput({tag, "_vec"},  vec1, v.expVec);
    endtask

    task automatic drive8(input logic [7:0] src, input logic selIe, input logic selIf,
                          input logic [7:0] di, input logic ack);
        src2 = src; selIe2 = selIe; selIf2 = selIf; wr2 = selIe | selIf; di2 = di; ack2 = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] expIf, input logic [7:0] expIe,
                          input logic expIrqN, input logic [7:0] expVec);
        checkOutput({tag, "_if"},   ifDo2, expIf);
        checkOutput({tag, "_ie"},   ieDo2, expIe);
        checkOutput({tag, "_irqn"}, {7'b0, irqN2}, {7'b0, expIrqN});
        checkOutput({tag, "_vec"},  vec2, expVec);
    endtask

    initial begin
        // src1 idles at 5'b10000 because source 4 is active-low.
        //                  src       ie   if   wr  di     ack  expIf  expIe  irqN expVec
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h00, 1, 8'h55));
        vecs.push_back(mkVec(5'b10000, 1, 0, 1, 8'h04, 0, 8'hE0, 8'h04, 1, 8'h55));
        vecs.push_back(mkVec(5'b10100, 0, 0, 0, 8'h00, 0, 8'hE4, 8'h04, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE4, 8'h04, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hE4, 8'h04, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hE4, 8'h04, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h04, 1, 8'h55));
        // priority and freeze
        vecs.push_back(mkVec(5'b10000, 1, 0, 1, 8'h1F, 0, 8'hE0, 8'h1F, 1, 8'h55));
        vecs.push_back(mkVec(5'b11010, 0, 0, 0, 8'h00, 0, 8'hEA, 8'h1F, 0, 8'h48));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hEA, 8'h1F, 0, 8'h48));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hEA, 8'h1F, 0, 8'h48));
        vecs.push_back(mkVec(5'b10001, 0, 0, 0, 8'h00, 1, 8'hEB, 8'h1F, 0, 8'h48));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE9, 8'h1F, 0, 8'h40));
        // active-low joypad edge
        vecs.push_back(mkVec(5'b10000, 0, 1, 1, 8'h00, 0, 8'hE0, 8'h1F, 1, 8'h55));
        vecs.push_back(mkVec(5'b00000, 0, 0, 0, 8'h00, 0, 8'hF0, 8'h1F, 0, 8'h60));
        vecs.push_back(mkVec(5'b00000, 0, 1, 1, 8'h00, 0, 8'hE0, 8'h1F, 1, 8'h55));
        vecs.push_back(mkVec(5'b00000, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h1F, 1, 8'h55));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h1F, 1, 8'h55));
        // collisions on the clear cycle
        vecs.push_back(mkVec(5'b10100, 0, 0, 0, 8'h00, 0, 8'hE4, 8'h1F, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hE4, 8'h1F, 0, 8'h50));
        vecs.push_back(mkVec(5'b10100, 0, 0, 0, 8'h00, 0, 8'hE4, 8'h1F, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hE4, 8'h1F, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 1, 1, 8'h04, 0, 8'hE4, 8'h1F, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hE4, 8'h1F, 0, 8'h50));
        vecs.push_back(mkVec(5'b10000, 0, 1, 1, 8'h00, 0, 8'hE0, 8'h1F, 1, 8'h55));
        // unimplemented register bits
        vecs.push_back(mkVec(5'b10000, 1, 0, 1, 8'hFF, 0, 8'hE0, 8'h1F, 1, 8'h55));
        vecs.push_back(mkVec(5'b10000, 0, 1, 1, 8'hFF, 0, 8'hFF, 8'h1F, 0, 8'h40));
        vecs.push_back(mkVec(5'b10000, 0, 1, 1, 8'h00, 0, 8'hE0, 8'h1F, 1, 8'h55));
        // ack with nothing pending, then an event while frozen on the default
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hE0, 8'h1F, 1, 8'h55));
        vecs.push_back(mkVec(5'b10001, 0, 0, 0, 8'h00, 1, 8'hE1, 8'h1F, 0, 8'h55));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE1, 8'h1F, 0, 8'h40));
        vecs.push_back(mkVec(5'b10000, 0, 1, 1, 8'h00, 0, 8'hE0, 8'h1F, 1, 8'h55));
        // IE gating of a level source
        vecs.push_back(mkVec(5'b10000, 1, 0, 1, 8'h00, 0, 8'hE0, 8'h00, 1, 8'h55));
        vecs.push_back(mkVec(5'b10010, 0, 0, 0, 8'h00, 0, 8'hE2, 8'h00, 1, 8'h55));
        vecs.push_back(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE2, 8'h00, 1, 8'h55));
        vecs.push_back(mkVec(5'b10000, 0, 1, 1, 8'h00, 0, 8'hE0, 8'h00, 1, 8'h55));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_if",   ifDo1, 8'hE0);
        checkOutput("rst_vec",  vec1, 8'h55);
        checkOutput("rst8_if",  ifDo2, 8'h00);
        checkOutput("rst8_vec", vec2, 8'h55);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkRow(vecs[i], $sformatf("r%0d", i));
        end

        // Reset asserted mid-ack must take effect without waiting for a clock.
        applyStimulus(mkVec(5'b10000, 1, 0, 1, 8'h04, 0, 8'h00, 8'h00, 1, 8'h00));
        applyStimulus(mkVec(5'b10100, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00));
        applyStimulus(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 8'h00));
        checkOutput("mid_ack_vec", vec1, 8'h50);
        reset = 1'b1;
        #1;
        checkRow(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h00, 1, 8'h55), "async_rst");
        ack1 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00));
        checkRow(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h00, 1, 8'h55), "post_rst");
        applyStimulus(mkVec(5'b10000, 1, 0, 1, 8'h04, 0, 8'h00, 8'h00, 1, 8'h00));
        applyStimulus(mkVec(5'b10100, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00));
        applyStimulus(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 8'h00));
        checkRow(mkVec(5'b10000, 0, 0, 0, 8'h00, 1, 8'hE4, 8'h04, 0, 8'h50), "re_ack");
        applyStimulus(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00));
        checkRow(mkVec(5'b10000, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h04, 1, 8'h55), "re_clr");

        // Eight level sources, vector base near the top so source 7 wraps.
        check8("c8_idle", 8'h00, 8'h00, 1, 8'h55);
        drive8(8'h00, 1, 0, 8'h80, 0);
        check8("c8_ie", 8'h00, 8'h80, 1, 8'h55);
        drive8(8'h80, 0, 0, 8'h00, 0);
        check8("c8_set", 8'h80, 8'h80, 0, 8'h28);
        drive8(8'h80, 0, 0, 8'h00, 1);
        check8("c8_ack", 8'h80, 8'h80, 0, 8'h28);
        drive8(8'h80, 0, 0, 8'h00, 0);
        check8("c8_reset_by_level", 8'h80, 8'h80, 0, 8'h28);
        drive8(8'h80, 0, 1, 8'h00, 0);
        check8("c8_level_beats_wr", 8'h80, 8'h80, 0, 8'h28);
        drive8(8'h00, 0, 1, 8'h00, 0);
        check8("c8_clear", 8'h00, 8'h80, 1, 8'h55);
        drive8(8'h00, 0, 0, 8'h00, 0);
        check8("c8_stay", 8'h00, 8'h80, 1, 8'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
